mips_multicycle_control: RTL and testbench

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

---
 rtl/mips_multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM for lw, sw, R-type, beq, j and addi.
// Define MEM_WAIT_EN to add a mem_ready handshake that stretches FETCH, MEM_READ and MEM_WRITE.
module mips_multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
`ifdef MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               pc_write,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               retire_s;
  logic               ready_s;
  logic [COUNT_W-1:0] count_r;

`ifdef MEM_WAIT_EN
  assign ready_s = mem_ready;
`else
  assign ready_s = 1'b1;
`endif

  // Next-state logic; retire_s marks the final cycle of every legal instruction
  always_comb begin
    state_next_s = S_FETCH;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (ready_s) state_next_s = S_DECODE;
        else         state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
          OP_RTYPE:     state_next_s = S_EXECUTE;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_J:         state_next_s = S_JUMP;
          OP_ADDI:      state_next_s = S_ADDI_EX;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_SW) state_next_s = S_MEM_WRITE;
        else                 state_next_s = S_MEM_READ;
      end
      S_MEM_READ: begin
        if (ready_s) state_next_s = S_MEM_WB;
        else         state_next_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (ready_s) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_MEM_WRITE;
        end
      end
      S_EXECUTE: state_next_s = S_R_WB;
      S_ADDI_EX: state_next_s = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      count_r <= {COUNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (retire_s) count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
      else          count_r <= count_r;
    end
  end

  // Moore output decode; reset forces every enable low and leaves FETCH mux settings
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal_op = 1'b0;
    if (reset) begin
      alu_src_b = 2'b01;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = ready_s;
          pc_write  = ready_s;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        S_MEM_ADDR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_source = 2'b01;
          pc_write  = zero;
        end
        S_JUMP: begin
          pc_source = 2'b10;
          pc_write  = 1'b1;
        end
        S_ADDI_WB: reg_write = 1'b1;
        default:   illegal_op = 1'b0;
      endcase
    end
  end

  assign state       = state_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: instruction-level model predicts per-cycle state, controls and counts
// for a 32-bit-count instance and a 4-bit-count instance driven in lockstep.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       zero = 1'b0;
  logic [5:0] opcode = 6'd0;
`ifdef MEM_WAIT_EN
  logic       mem_ready = 1'b1;
`endif

  logic pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [31:0] instr_count;

  logic pc_write4, ir_write4, i_or_d4, mem_read4, mem_write4, mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, illegal_op4;
  logic [1:0] alu_src_b4, alu_op4, pc_source4;
  logic [3:0] state4;
  logic [3:0] instr_count4;

  mips_multicycle_control #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  mips_multicycle_control #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .pc_write(pc_write4), .ir_write(ir_write4), .i_or_d(i_or_d4), .mem_read(mem_read4),
    .mem_write(mem_write4), .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4), .reg_write(reg_write4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4), .pc_source(pc_source4),
    .state(state4), .illegal_op(illegal_op4), .instr_count(instr_count4)
  );

  logic [15:0] act_ctrl, act_ctrl4;
  assign act_ctrl  = {pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write,
                      alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
  assign act_ctrl4 = {pc_write4, ir_write4, i_or_d4, mem_read4, mem_write4, mem_to_reg4, reg_dst4, reg_write4,
                      alu_src_a4, alu_src_b4, alu_op4, pc_source4, illegal_op4};

  int n_cmp = 0;
  int n_err = 0;
  int model_cnt = 0;
  bit cnt_known = 1'b0;
  bit chk_en = 1'b0;
  int exp_state = -1;
  logic [15:0] exp_ctrl = 16'd0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Control table written straight from the per-state requirements
  function automatic logic [15:0] ctrl_of(input int st, input logic z, input logic rdy, input logic rst,
                                          input logic [5:0] op);
    logic pcw, irw, iod, mr, mw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, irw, iod, mr, mw, m2r, rd, rw, asa, ill} = 10'd0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (rst) asb = 2'b01;
    else begin
      case (st)
        0:      begin mr = 1'b1; asb = 2'b01; pcw = rdy; irw = rdy; end
        1:      begin asb = 2'b11; ill = !legal(op); end
        2, 10:  begin asa = 1'b1; asb = 2'b10; end
        3:      begin mr = 1'b1; iod = 1'b1; end
        4:      begin rw = 1'b1; m2r = 1'b1; end
        5:      begin mw = 1'b1; iod = 1'b1; end
        6:      begin asa = 1'b1; aop = 2'b10; end
        7:      begin rw = 1'b1; rd = 1'b1; end
        8:      begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pcw = z; end
        9:      begin pcs = 2'b10; pcw = 1'b1; end
        11:     rw = 1'b1;
        default: ;
      endcase
    end
    return {pcw, irw, iod, mr, mw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  // Single compare process, sampling mid-cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_state >= 0) begin
        cmp("state", int'(state), exp_state);
        cmp("state4", int'(state4), exp_state);
      end
      cmp("ctrl", int'(act_ctrl), int'(exp_ctrl));
      cmp("ctrl4", int'(act_ctrl4), int'(exp_ctrl));
      if (cnt_known) begin
        cmp("count", int'(instr_count), model_cnt);
        cmp("count4", int'(instr_count4), model_cnt & 15);
      end
    end
  end

  // One clock cycle: drive inputs, publish expectation, advance past the edge
  task automatic cyc(input int st, input bit rdy, input bit rst, input int zsel);
    reset = rst;
    if (zsel < 0) zero = 1'($urandom_range(0, 1));
    else          zero = 1'(zsel);
`ifdef MEM_WAIT_EN
    mem_ready = rdy;
`endif
    exp_state = st;
    exp_ctrl  = ctrl_of(st, zero, rdy, rst, opcode);
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
    if (rst) begin
      model_cnt = 0;
      cnt_known = 1'b1;
    end
  endtask

  // Run one instruction; abort_at = step index where reset hits (-1 none, -2 random)
  task automatic run_instr(input logic [5:0] op, input int zsel, input int abort_at, input int fetch_wait);
    int path[$];
    int ab;
    int nw;
    opcode = op;
    path = {0, 1};
    case (op)
      OP_LW:   path = {path, 2, 3, 4};
      OP_SW:   path = {path, 2, 5};
      OP_R:    path = {path, 6, 7};
      OP_BEQ:  path = {path, 8};
      OP_J:    path = {path, 9};
      OP_ADDI: path = {path, 10, 11};
      default: ;
    endcase
    ab = abort_at;
    if (ab == -2) ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, path.size() - 1) : -1;
    for (int i = 0; i < path.size(); i++) begin
      if (i == ab) begin
        cyc(path[i], 1'b1, 1'b1, zsel);
        return;
      end
      nw = 0;
`ifdef MEM_WAIT_EN
      if (path[i] == 0 || path[i] == 3 || path[i] == 5)
        nw = (path[i] == 0 && fetch_wait >= 0) ? fetch_wait : $urandom_range(0, 2);
`endif
      for (int w = 0; w < nw; w++) cyc(path[i], 1'b0, 1'b0, zsel);
      cyc(path[i], 1'b1, 1'b0, zsel);
    end
    if (legal(op)) model_cnt = model_cnt + 1;
  endtask

  initial begin
    int sel;
    logic [5:0] op;
    logic [5:0] pool [6];
    pool = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI};

    // Reset for two cycles, then one lw
    cyc(-1, 1'b1, 1'b1, 0);
    cyc(0, 1'b1, 1'b1, 0);
    run_instr(OP_LW, -1, -1, -1);
    cmp("lw_count_lit", int'(instr_count), 1);
    cmp("lw_state_lit", int'(state), 0);

    // beq taken then not taken: both retire
    run_instr(OP_BEQ, 1, -1, -1);
    run_instr(OP_BEQ, 0, -1, -1);
    cmp("beq_count_lit", int'(instr_count), 3);

    // Unsupported opcode: no count
    run_instr(6'b111111, -1, -1, -1);
    cmp("illegal_count_lit", int'(instr_count), 3);

    // Reset during MEM_WRITE of a sw
    run_instr(OP_SW, -1, 3, -1);
    cmp("sw_abort_state_lit", int'(state), 0);
    cmp("sw_abort_count_lit", int'(instr_count), 0);

    // Long FETCH stall when mem_ready handshaking is built in
    run_instr(OP_R, -1, -1, 3);

    // 16 R-types from reset: 4-bit counter wraps to zero
    cyc(int'(state), 1'b1, 1'b1, 0);
    for (int k = 0; k < 16; k++) run_instr(OP_R, -1, -1, -1);
    cmp("wrap_count4_lit", int'(instr_count4), 0);
    cmp("wrap_count32_lit", int'(instr_count), 16);

    // Random instruction mix with random zero, illegal opcodes and occasional resets
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 7);
      if (sel < 6) op = pool[sel];
      else         op = 6'($urandom_range(0, 63));
      run_instr(op, -1, -2, -1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
